// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. It walks sequential PCs, fetches words over a
// req/gnt/rvalid memory port with at most one request in flight, and buffers
// the {pc, instr} pairs in a small FIFO. The FIFO head is handed to the IF/ID
// register, and the unit falls back to a NOP bubble when it has nothing valid.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_write
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic             outstanding;
  logic             discard;

  fetch_entry_t     buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0]      redirect_target;
  logic [CNT_W-1:0] in_use;
  logic             fifo_empty;
  logic             grant;
  logic             resp;
  logic             push;
  logic             pop;
  fetch_entry_t     head;

  assign redirect_target = redirect_pc & ~32'h3;
  assign fifo_empty      = (count == '0);
  assign in_use          = count + CNT_W'(outstanding);

  // A new request may go out once the previous one is answered (possibly this
  // very cycle) and the FIFO still has room for everything in flight. The
  // reset gate keeps the port quiet while the unit is held in reset.
  assign imem_req  = reset && (!outstanding || imem_rvalid) && (in_use < CNT_W'(BUF_DEPTH));
  assign imem_addr = fetch_pc;

  assign grant = imem_req && imem_gnt;
  // A response with nothing in flight is stale (e.g. issued before a reset) and is ignored.
  assign resp  = imem_rvalid && outstanding;
  // A redirect flushes the FIFO, so a word landing in that cycle is discarded too.
  assign push  = resp && !discard && !redirect_valid;
  assign pop   = !redirect_valid && !stall && !fifo_empty;
  assign head  = buf_mem[rd_ptr];

  // Fetch PC, in-flight tracking and wrong-path discard flag.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (grant) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
      end else if (resp) begin
        outstanding <= 1'b0;
      end

      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        // Whatever is still in flight, or is granted right now, is wrong-path.
        discard  <= (outstanding && !resp) || grant;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (resp)  discard  <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; an entry is only read after the
  // pointer logic says it was written, so clearing it would be wasted logic.
  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= '{pc: req_pc, instr: imem_rdata};
  end

  // IF/ID hand-over: flush bubble, stall hold, FIFO head, or idle bubble.
  // NOTE: every output gets a default first so no path through this block
  // can leave a value unassigned and infer a latch.
  always_comb begin
    ifid_write = 1'b1;
    ifid_pc    = 32'h0;
    ifid_instr = NOP_INSTR;
    if (!redirect_valid) begin
      ifid_write = !stall;
      if (!fifo_empty) begin
        ifid_pc    = head.pc;
        ifid_instr = head.instr;
      end
    end
  end

  // A response is only legal while a fetch is in flight. The first edge after
  // reset release is exempt: a fetch issued before the reset may answer then.
  assert property (@(posedge clk) disable iff (!reset)
                   (imem_rvalid && $past(reset)) |-> outstanding);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a per-cycle vector table for the main pipeline
// behaviour, hand-written sequences for the multi-cycle corner cases, and a
// scoreboard that pairs every granted fetch address with the word that later
// reaches IF/ID.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;
  localparam int   N_VEC = 23;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_write;

  int n_checks = 0;
  int n_pass   = 0;

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_write     (ifid_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Instruction memory contents: never equal to the NOP encoding.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // ---------------- instruction memory model ----------------
  int          lat = 1;
  bit          stale = 1'b0;
  bit          pend_valid = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (pend_valid) begin
        if (pend_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = stale ? 32'hBAD0_BAD0 : mem_word(pend_addr);
          pend_valid  = 1'b0;
          stale       = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      #1;
      imem_gnt = imem_req && !pend_valid;
      if (imem_gnt) begin
        pend_valid = 1'b1;
        pend_cnt   = lat;
        pend_addr  = imem_addr;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  function automatic bit is_bubble();
    return (ifid_instr === NOP) && (ifid_pc === 32'h0);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!reset || redirect_valid) begin
        exp_q.delete();
      end else begin
        if (ifid_write && !is_bubble()) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: pc %h instr %h delivered, none expected", ifid_pc, ifid_instr);
          end else begin
            logic [31:0] a;
            a = exp_q.pop_front();
            check("sb_pc", ifid_pc, a);
            check("sb_instr", ifid_instr, mem_word(a));
          end
        end
        if (imem_req && imem_gnt) exp_q.push_back(imem_addr);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_reset_outputs();
    check("rst_req",   32'(imem_req),   32'h0);
    check("rst_write", 32'(ifid_write), 32'h1);
    check("rst_instr", ifid_instr,      NOP);
    check("rst_pc",    ifid_pc,         32'h0);
  endtask

  task automatic do_reset(input int latency);
    @(posedge clk);
    #3;
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    check_reset_outputs();
    lat = latency;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  task automatic expect_next_word(input string name, input logic [31:0] pc);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (ifid_write && !is_bubble()) found = 1'b1;
    end
    if (found) begin
      check({name, "_pc"}, ifid_pc, pc);
      check({name, "_instr"}, ifid_instr, mem_word(pc));
    end else begin
      n_checks++;
      $display("FAIL %s: no word delivered within 20 cycles, expected pc %h", name, pc);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic        bub;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic rq, input logic [31:0] ad,
                              input logic wr, input logic bub, input logic [31:0] pc);
    vec_t v;
    v.stall = s;  v.redir = r;  v.rpc = rpc;
    v.req = rq;   v.addr = ad;
    v.wr = wr;    v.bub = bub;  v.pc = pc;
    return v;
  endfunction

  vec_t vt [N_VEC];

  initial begin
    // Memory latency 1, always granting. One row per cycle after reset release.
    //           stall redir rpc            req  addr          wr bub pc
    vt[0]  = mk(L, L, 32'h0,   H, 32'h000, H, H, 32'h0);    // first fetch, bubble
    vt[1]  = mk(L, L, 32'h0,   H, 32'h004, H, H, 32'h0);
    vt[2]  = mk(L, L, 32'h0,   L, 32'h0,   H, L, 32'h000);  // gnt->rvalid 1 => word at +2
    vt[3]  = mk(L, L, 32'h0,   H, 32'h008, H, L, 32'h004);
    vt[4]  = mk(L, H, 32'h100, H, 32'h00C, H, H, 32'h0);    // redirect, 0x8 returns now
    vt[5]  = mk(L, L, 32'h0,   H, 32'h100, H, H, 32'h0);    // 0xC discarded
    vt[6]  = mk(L, L, 32'h0,   H, 32'h104, H, H, 32'h0);
    vt[7]  = mk(L, L, 32'h0,   L, 32'h0,   H, L, 32'h100);
    vt[8]  = mk(L, L, 32'h0,   H, 32'h108, H, L, 32'h104);
    vt[9]  = mk(H, H, 32'h203, H, 32'h10C, H, H, 32'h0);    // flush beats stall, low bits dropped
    vt[10] = mk(L, L, 32'h0,   H, 32'h200, H, H, 32'h0);
    vt[11] = mk(L, L, 32'h0,   H, 32'h204, H, H, 32'h0);
    vt[12] = mk(L, L, 32'h0,   L, 32'h0,   H, L, 32'h200);
    vt[13] = mk(L, L, 32'h0,   H, 32'h208, H, L, 32'h204);
    vt[14] = mk(H, L, 32'h0,   H, 32'h20C, L, L, 32'h0);    // stall: hold IF/ID
    vt[15] = mk(H, L, 32'h0,   L, 32'h0,   L, L, 32'h0);
    vt[16] = mk(H, L, 32'h0,   L, 32'h0,   L, L, 32'h0);    // FIFO full, no request
    vt[17] = mk(H, L, 32'h0,   L, 32'h0,   L, L, 32'h0);
    vt[18] = mk(H, L, 32'h0,   L, 32'h0,   L, L, 32'h0);
    vt[19] = mk(L, L, 32'h0,   L, 32'h0,   H, L, 32'h208);  // resume, nothing lost
    vt[20] = mk(L, L, 32'h0,   H, 32'h210, H, L, 32'h20C);
    vt[21] = mk(L, L, 32'h0,   H, 32'h214, H, H, 32'h0);
    vt[22] = mk(L, L, 32'h0,   L, 32'h0,   H, L, 32'h210);

    do_reset(1);
    for (int i = 0; i < N_VEC; i++) begin
      @(posedge clk);
      #1;
      stall          = vt[i].stall;
      redirect_valid = vt[i].redir;
      redirect_pc    = vt[i].rpc;
      @(negedge clk);
      check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vt[i].req));
      if (vt[i].req) check($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
      check($sformatf("v%0d_write", i), 32'(ifid_write), 32'(vt[i].wr));
      if (vt[i].wr) begin
        check($sformatf("v%0d_pc", i), ifid_pc, vt[i].bub ? 32'h0 : vt[i].pc);
        check($sformatf("v%0d_instr", i), ifid_instr, vt[i].bub ? NOP : mem_word(vt[i].pc));
      end
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
    redirect_valid = 1'b0;

    // Redirect to 0x100 while the fetch of 0x8 is outstanding (latency 2).
    do_reset(2);
    repeat (6) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("redir_out_req",   32'(imem_req),   32'h0);
    check("redir_out_write", 32'(ifid_write), 32'h1);
    check("redir_out_instr", ifid_instr,      NOP);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_tgt_req",  32'(imem_req), 32'h1);
    check("redir_tgt_addr", imem_addr,     32'h100);
    expect_next_word("redir_first", 32'h100);

    // Fetch PC wrap at the top of the address space (latency 1).
    do_reset(1);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_req0",  32'(imem_req), 32'h1);
    check("wrap_addr0", imem_addr,     32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_req1",  32'(imem_req), 32'h1);
    check("wrap_addr1", imem_addr,     32'h0000_0000);
    @(negedge clk);
    check("wrap_pc_top", ifid_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc_zero",    ifid_pc,    32'h0);
    check("wrap_instr_zero", ifid_instr, mem_word(32'h0));

    // Reset during an outstanding fetch; the stale response lands after release.
    do_reset(3);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    stale = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    expect_next_word("post_reset", 32'h0);

    repeat (8) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

endmodule
